// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the instruction-cache refill arbiter.
package icache_refill_pkg;

    typedef logic [3:0][31:0] line_t;

    function automatic int idx_width(input int nb_req);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < nb_req) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/refill_id_fifo.sv
// In-order FIFO of requester indices for refills still waiting on memory.
module refill_id_fifo
    import icache_refill_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] slot_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;

    // Storage, wrapping pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            if (push) begin
                slot_r[wr_ptr_r] <= din;
                wr_ptr_r         <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == '0);
    assign head  = slot_r[rd_ptr_r];

endmodule

// File: rtl/icache_refill_arbiter.sv
// Round-robin arbitration of cache-line refills onto one memory port,
// with in-order routing of memory responses back to the requester.
module icache_refill_arbiter
    import icache_refill_pkg::*;
#(
    parameter int NB_REQ        = 4,
    parameter int ADDR_WIDTH    = 16,
    parameter int OUTSTND_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NB_REQ-1:0]                   req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
    output logic [NB_REQ-1:0]                   gnt_o,
    output logic [NB_REQ-1:0]                   r_valid_o,
    output line_t                               r_rdata_o,
    output logic                                mem_req_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_r_valid_i,
    input  line_t                               mem_r_rdata_i,
    output logic                                err_o
);

    localparam int IDX_W = idx_width(NB_REQ);
    localparam logic [NB_REQ-1:0] ONE_HOT_BASE = {{(NB_REQ - 1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] rr_ptr_r;
    logic             lock_valid_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] rr_idx_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] rr_next_s;
    logic [IDX_W-1:0] head_s;
    logic             any_req_s;
    logic             accept_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] ptr, input int i);
        return IDX_W'((int'(ptr) + i) % NB_REQ);
    endfunction

    // Round-robin search from rr_ptr_r; descending sweep leaves the nearest requester.
    always_comb begin
        rr_idx_s = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            if (req_i[rr_cand(rr_ptr_r, i)]) begin
                rr_idx_s = rr_cand(rr_ptr_r, i);
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
    end

    // A request offered but refused by memory keeps its slot while still asserted.
    always_comb begin
        if (lock_valid_r && req_i[lock_idx_r]) begin
            winner_s = lock_idx_r;
        end else begin
            winner_s = rr_idx_s;
        end
    end

    assign any_req_s  = |req_i;
    // A response in the same cycle frees a slot, so a full table may still accept.
    assign mem_req_o  = ~rst & any_req_s & (~full_s | mem_r_valid_i);
    assign mem_addr_o = addr_i[winner_s];
    assign accept_s   = mem_req_o & mem_gnt_i;
    assign gnt_o      = accept_s ? (ONE_HOT_BASE << winner_s) : '0;
    assign rr_next_s  = (winner_s == IDX_W'(NB_REQ - 1)) ? '0 : winner_s + 1'b1;

    assign pop_s      = ~rst & mem_r_valid_i & ~empty_s;
    assign r_valid_o  = pop_s ? (ONE_HOT_BASE << head_s) : '0;
    assign r_rdata_o  = pop_s ? mem_r_rdata_i : '0;

    // Arbitration pointer, pending-request lock and sticky unexpected-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r     <= '0;
            lock_valid_r <= 1'b0;
            lock_idx_r   <= '0;
            err_o        <= 1'b0;
        end else begin
            if (accept_s) begin
                rr_ptr_r <= rr_next_s;
            end
            lock_valid_r <= mem_req_o & ~mem_gnt_i;
            lock_idx_r   <= winner_s;
            if (mem_r_valid_i && empty_s) begin
                err_o <= 1'b1;
            end
        end
    end

    refill_id_fifo #(
        .DEPTH (OUTSTND_DEPTH),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .din   (winner_s),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_icache_refill_arbiter;
    import icache_refill_pkg::*;

    localparam int NB    = 4;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic [NB-1:0]        req;
    logic [NB-1:0][AW-1:0] addr;
    logic [NB-1:0]        gnt;
    logic [NB-1:0]        r_valid;
    line_t                r_rdata;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    line_t                mem_rdata;
    logic                 err;

    icache_refill_arbiter #(
        .NB_REQ        (NB),
        .ADDR_WIDTH    (AW),
        .OUTSTND_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .addr_i        (addr),
        .gnt_o         (gnt),
        .r_valid_o     (r_valid),
        .r_rdata_o     (r_rdata),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_r_valid_i (mem_rvalid),
        .mem_r_rdata_i (mem_rdata),
        .err_o         (err)
    );

    typedef struct {
        int            id;
        logic [AW-1:0] a;
        int            ready;
    } txn_t;

    txn_t          q[$];
    int            rr_start, pend_idx, cyc, lat, acc_idx, n_grants;
    int            n_checks, n_pass;
    bit            pend_valid, err_m, rand_resp;
    logic [NB-1:0] obs_gnt, obs_rv;
    logic [AW-1:0] obs_addr;
    logic          obs_memreq;
    line_t         obs_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic line_t line_of(input logic [AW-1:0] a);
        line_t l;
        for (int j = 0; j < 4; j++) l[j] = (32'(a) << 4) + 32'(4 * j);
        return l;
    endfunction

    // One clock cycle: predict from the model, sample at mid-cycle, advance the model.
    task automatic step(input bit auto_mem);
        int            w, k;
        bit            found, full_m, exp_mr, popm;
        logic [NB-1:0] e_gnt, e_rv;
        line_t         e_rd;
        txn_t          t;
        if (auto_mem)
            mem_rvalid = (q.size() > 0) && (q[0].ready <= cyc) && (!rand_resp || $urandom_range(0, 3) != 0);
        if (mem_rvalid && q.size() > 0) mem_rdata = line_of(q[0].a);
        else for (int j = 0; j < 4; j++) mem_rdata[j] = $urandom();
        full_m = (q.size() == DEPTH);
        exp_mr = (req != '0) && (!full_m || mem_rvalid);
        w = 0;
        if (pend_valid && req[pend_idx]) begin
            w = pend_idx;
        end else begin
            found = 1'b0;
            for (int i = 0; i < NB; i++) begin
                k = (rr_start + i) % NB;
                if (!found && req[k]) begin
                    w = k;
                    found = 1'b1;
                end
            end
        end
        e_gnt = (exp_mr && mem_gnt) ? (NB'(1) << w) : '0;
        popm  = mem_rvalid && q.size() > 0;
        e_rv  = popm ? (NB'(1) << q[0].id) : '0;
        e_rd  = popm ? line_of(q[0].a) : '0;
        #4;
        check_val("mem_req", 128'(mem_req), 128'(exp_mr));
        if (exp_mr) check_val("mem_addr", 128'(mem_addr), 128'(addr[w]));
        check_val("gnt", 128'(gnt), 128'(e_gnt));
        check_val("r_valid", 128'(r_valid), 128'(e_rv));
        check_val("r_rdata", 128'(r_rdata), 128'(e_rd));
        check_val("err", 128'(err), 128'(err_m));
        obs_gnt = gnt; obs_rv = r_valid; obs_rd = r_rdata; obs_memreq = mem_req; obs_addr = mem_addr;
        if (mem_rvalid && q.size() == 0) err_m = 1'b1;
        if (popm) void'(q.pop_front());
        acc_idx = -1;
        if (exp_mr && mem_gnt) begin
            t.id = w; t.a = addr[w]; t.ready = cyc + lat;
            q.push_back(t);
            rr_start = (w + 1) % NB;
            acc_idx = w;
        end
        pend_valid = exp_mr && !mem_gnt;
        pend_idx = w;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b1111; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        #2;
        check_val("rst_mem_req", 128'(mem_req), 128'(0));
        check_val("rst_gnt", 128'(gnt), 128'(0));
        check_val("rst_r_valid", 128'(r_valid), 128'(0));
        check_val("rst_err", 128'(err), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        q.delete(); rr_start = 0; pend_valid = 1'b0; pend_idx = 0; err_m = 1'b0; cyc = 0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; lat = 1; rand_resp = 1'b0; acc_idx = -1;
        rst = 1'b1; req = '0; addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        do_reset();

        // Single requester, latency 1.
        req = 4'b0001; addr[0] = 16'h0010; mem_gnt = 1'b1; lat = 1;
        step(1'b1);
        check_val("t1_gnt", 128'(obs_gnt), 128'(4'b0001));
        req = '0;
        step(1'b1);
        check_val("t1_rvalid", 128'(obs_rv), 128'(4'b0001));
        check_val("t1_rdata", 128'(obs_rd), 128'h0000010C_00000108_00000104_00000100);

        // All four requesting continuously.
        do_reset();
        for (int k = 0; k < NB; k++) addr[k] = AW'(16'h0100 + k);
        req = 4'b1111; mem_gnt = 1'b1; lat = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check_val($sformatf("t2_order%0d", i), 128'(acc_idx), 128'(i % 4));
        end
        req = '0;
        repeat (2) step(1'b1);

        // Memory stalls the grant; a newcomer must not steal the pending slot.
        do_reset();
        addr[0] = 16'h0AA0; addr[1] = 16'h0AA1; addr[2] = 16'h0AA2;
        req = 4'b0110; mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req[0] = 1'b1;
            step(1'b1);
            check_val("t3_addr", 128'(obs_addr), 128'(16'h0AA1));
            check_val("t3_nogrant", 128'(obs_gnt), 128'(0));
        end
        mem_gnt = 1'b1;
        step(1'b1);
        check_val("t3_gnt", 128'(obs_gnt), 128'(4'b0010));
        req = '0;
        repeat (2) step(1'b1);

        // Long latency fills the outstanding table.
        do_reset();
        req = 4'b1111; mem_gnt = 1'b1; lat = 10; n_grants = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1);
            if (acc_idx >= 0) n_grants++;
            if (i == 6) check_val("t4_stall", 128'(obs_memreq), 128'(0));
            if (i == 9) check_val("t4_grants", 128'(n_grants), 128'(4));
            if (i == 10) check_val("t4_resp_gnt", 128'(obs_gnt != '0), 128'(1));
        end
        req = '0;
        repeat (16) step(1'b1);

        // Unexpected response.
        do_reset();
        mem_rvalid = 1'b1;
        step(1'b0);
        check_val("t5_rvalid", 128'(obs_rv), 128'(0));
        mem_rvalid = 1'b0;
        repeat (3) step(1'b0);
        check_val("t5_err", 128'(err), 128'(1));

        // Reset with refills in flight, stale response, then a fresh refill.
        do_reset();
        req = 4'b0111; mem_gnt = 1'b1; lat = 10;
        repeat (3) step(1'b1);
        do_reset();
        mem_rvalid = 1'b1;
        step(1'b0);
        check_val("t6_stale_rv", 128'(obs_rv), 128'(0));
        mem_rvalid = 1'b0; lat = 1; mem_gnt = 1'b1;
        req = 4'b0001; addr[0] = 16'h0123;
        step(1'b1);
        check_val("t6_gnt", 128'(obs_gnt), 128'(4'b0001));
        req = '0;
        step(1'b1);
        check_val("t6_rvalid", 128'(obs_rv), 128'(4'b0001));
        check_val("t6_err", 128'(err), 128'(1));

        // Randomized traffic.
        do_reset();
        rand_resp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            mem_gnt = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 6);
            for (int k = 0; k < NB; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    addr[k] = AW'($urandom());
                end
            end
            step(1'b1);
            if (acc_idx >= 0) req[acc_idx] = 1'b0;
        end
        req = '0; mem_gnt = 1'b0;
        repeat (40) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_refill_arbiter.md
ICACHE_REFILL_ARBITER -- requirements
Module: icache_refill_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 4, number of refill requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, 128-bit-line address width.
REQ-003 SHALL have parameter OUTSTND_DEPTH, default 4, maximum in-flight memory reads (power of 2, >=2).
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: req_i  in  NB_REQ  per-requester refill request.
REQ-007 SHALL have port: addr_i  in  NB_REQ x ADDR_WIDTH  per-requester line address.
REQ-008 SHALL have port: gnt_o  out  NB_REQ  per-requester grant, one-hot or zero.
REQ-009 SHALL have port: r_valid_o  out  NB_REQ  per-requester response valid, one-hot or zero.
REQ-010 SHALL have port: r_rdata_o  out  4x32  shared response line, valid for the flagged requester.
REQ-011 SHALL have port: mem_req_o  out  1  memory request.
REQ-012 SHALL have port: mem_addr_o  out  ADDR_WIDTH  memory line address.
REQ-013 SHALL have port: mem_gnt_i  in  1  memory grant.
REQ-014 SHALL have port: mem_r_valid_i  in  1  memory response valid, in order, latency >=1 cycle after grant.
REQ-015 SHALL have port: mem_r_rdata_i  in  4x32  memory response line.
REQ-016 SHALL have port: err_o  out  1  sticky protocol error (unexpected response).

Function
REQ-017 Requester handshake: request accepted in cycle where req_i[k] & gnt_o[k]; requester holds req_i/addr_i stable until granted.
REQ-018 Arbitration: round-robin among asserted req_i, starting search at index after last granted; after reset, search starts at index 0.
REQ-019 mem_req_o SHALL be 1 when any req_i asserted and outstanding table not full; mem_addr_o = addr_i of winner, combinational.
REQ-020 gnt_o[winner] = mem_req_o & mem_gnt_i; round-robin pointer advances only on an accepted transfer.
REQ-021 If mem_gnt_i low, winner SHALL stay the same next cycle while its req_i remains (no re-arbitration of a pending memory request).
REQ-022 On each accepted transfer, winner index SHALL be pushed into an in-order ID FIFO of depth OUTSTND_DEPTH.
REQ-023 On mem_r_valid_i with FIFO non-empty: pop head, r_valid_o[head]=1 same cycle, r_rdata_o = mem_r_rdata_i (zero-latency response routing).
REQ-024 FIFO full: mem_req_o = 0, unless mem_r_valid_i asserted same cycle (simultaneous pop frees a slot; push and pop both occur).
REQ-025 FIFO empty and mem_r_valid_i = 1: response dropped, r_valid_o all zero, err_o set and held until reset.
REQ-026 Outstanding count SHALL be 0..OUTSTND_DEPTH with pointer wrap-around modulo depth; count unchanged on simultaneous push and pop.
REQ-027 r_rdata_o SHALL be 0 when mem_r_valid_i is low (no stale data leak).

Reset
REQ-028 While rst high: gnt_o=0, r_valid_o=0, mem_req_o=0, err_o=0, FIFO empty, round-robin pointer to index 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight IDs; memory responses arriving after reset release and before any new grant SHALL set err_o.

Structure
REQ-030 Shared package icache_refill_pkg SHALL hold the 4x32 line typedef and the requester-index width function (clog2 of NB_REQ).
REQ-031 ID FIFO SHALL be a separate sub-module refill_id_fifo (push, pop, full, empty, head data).
REQ-032 Round-robin arbiter SHALL be inline in icache_refill_arbiter.

Verification
REQ-033 Single requester: req_i=0001, addr 0x0010, mem_gnt_i=1, memory latency 1 -> gnt_o=0001 cycle 0, r_valid_o=0001 cycle 1, rdata = {0x10C,0x108,0x104,0x100}.
REQ-034 All four requesting continuously, mem_gnt_i=1 -> grant order 0,1,2,3,0; responses routed to same order.
REQ-035 mem_gnt_i low 3 cycles with req_i=0110 -> mem_addr_o stable at requester 1 address, gnt_o=0 until mem_gnt_i high, then gnt_o=0010.
REQ-036 Memory latency 10, OUTSTND_DEPTH=4, constant requests -> exactly 4 grants then mem_req_o=0 until first response; grant permitted in the response cycle.
REQ-037 mem_r_valid_i pulse with no outstanding request -> r_valid_o=0, err_o=1 persisting until rst.
REQ-038 rst pulse with 3 requests in flight -> all outputs zero, count 0; subsequent fresh request completes normally.
